// File: rtl/manual_dpc_pkg.sv
// Shared types and helpers for the manual bad-pixel region checker.
package manual_dpc_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_BUILD, ST_DRAIN, ST_READY} state_e;

  localparam int CFG_Y_LSB = 16;
  localparam int CFG_X_LSB = 0;
  localparam int WIDE_W    = 17;

  typedef struct packed {
    logic [WIDE_W-1:0] x_hi;
    logic [WIDE_W-1:0] x_lo;
  } region_t;

  function automatic logic [WIDE_W-1:0] sat_sub(input logic [WIDE_W-1:0] a,
                                                input logic [WIDE_W-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

  function automatic logic [WIDE_W-1:0] clamp_max(input logic [WIDE_W-1:0] a,
                                                  input logic [WIDE_W-1:0] lim);
    return (a > lim) ? lim : a;
  endfunction

endpackage

// File: rtl/manual_coord_ram.sv
// Bad-pixel coordinate table: one write port, one registered read port.
module manual_coord_ram #(
  parameter int PT_NUM = 128,
  parameter int PT_BIT = 7
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PT_BIT-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [PT_BIT-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [PT_NUM];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/manual_region_prefetch_checker.sv
// Flags pixels inside square regions around configured bad points; the next
// line's region list is prefetched into the idle half of a ping-pong cache.
module manual_region_prefetch_checker
  import manual_dpc_pkg::*;
#(
  parameter int X_BITS       = 10,
  parameter int Y_BITS       = 10,
  parameter int PT_NUM       = 128,
  parameter int PT_BIT       = 7,
  parameter int RADIUS       = 2,
  parameter int MAX_REGIONS  = 16,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic [X_BITS-1:0] pix_x,
  input  logic              sof,
  input  logic              sol,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [PT_BIT-1:0] cfg_addr,
  input  logic [31:0]       cfg_wdata,
  input  logic [PT_BIT:0]   cfg_num,
  output logic              match_valid,
  output logic              match,
  output logic              region_overflow,
  output logic              build_late,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_REGIONS) + 1;
  localparam logic [WIDE_W-1:0] RAD_W  = WIDE_W'(RADIUS);
  localparam logic [WIDE_W-1:0] XMAX_W = WIDE_W'(IMAGE_WIDTH - 1);
  localparam logic [PT_BIT:0]   ADDR_ONE = (PT_BIT+1)'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(MAX_REGIONS);

  state_e            state_q;
  logic              active_q, loaded_q, drain_q;
  logic [Y_BITS-1:0] target_q;
  logic [PT_BIT:0]   num_q, rd_addr_q;
  logic [CNT_W-1:0]  cnt_q [2];
  logic              vld_p0_q, vld_p1_q;
  logic [X_BITS-1:0] coord_x_p1_q;
  logic [Y_BITS-1:0] coord_y_p1_q;
  logic              overflow_q, late_q, match_q, match_valid_q;
  logic [X_BITS-1:0] slot_lo_q [2][MAX_REGIONS];
  logic [X_BITS-1:0] slot_hi_q [2][MAX_REGIONS];

  logic [31:0] rdata;
  logic        rdata_unused;

  manual_coord_ram #(.PT_NUM(PT_NUM), .PT_BIT(PT_BIT)) u_ram (
    .clk     (clk),
    .we_i    (cfg_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_wdata),
    .raddr_i (rd_addr_q[PT_BIT-1:0]),
    .rdata_o (rdata)
  );

  assign rdata_unused = ^{rdata[31:CFG_Y_LSB+Y_BITS], rdata[CFG_Y_LSB-1:CFG_X_LSB+X_BITS]};

  // Control decode: sof outranks sol, and any restart flushes the read pipeline.
  logic sof_go, late_sol, ready_sol, next_ok, start, flush;
  logic bld_bank, wr_bank;
  assign sof_go    = sof && enable;
  assign late_sol  = sol && !sof && (state_q == ST_BUILD || state_q == ST_DRAIN);
  assign ready_sol = sol && !sof && (state_q == ST_READY);
  assign next_ok   = (int'(target_q) + 1) < IMAGE_HEIGHT;
  assign start     = sof_go || ((late_sol || ready_sol) && next_ok);
  assign flush     = sof_go || late_sol || ready_sol;
  assign wr_bank   = ~active_q;
  assign bld_bank  = ready_sol ? active_q : ~active_q;

  // Evaluate stage: region bounds of the point fetched two cycles ago.
  region_t           reg_c;
  logic              hit, do_wr, do_ovf;
  logic [WIDE_W-1:0] bx_w, by_w, tgt_w;
  logic [CNT_W-1:0]  wr_cnt;
  assign bx_w   = WIDE_W'(coord_x_p1_q);
  assign by_w   = WIDE_W'(coord_y_p1_q);
  assign tgt_w  = WIDE_W'(target_q);
  assign wr_cnt = cnt_q[wr_bank];

  always_comb begin
    reg_c.x_lo = sat_sub(bx_w, RAD_W);
    reg_c.x_hi = clamp_max(bx_w + RAD_W, XMAX_W);
    hit = vld_p1_q && (sat_sub(by_w, RAD_W) <= tgt_w) && (tgt_w <= by_w + RAD_W);
  end

  assign do_wr  = hit && !flush && (wr_cnt != CNT_FULL);
  assign do_ovf = hit && !flush && (wr_cnt == CNT_FULL);

  logic any_hit;
  always_comb begin
    any_hit = 1'b0;
    for (int i = 0; i < MAX_REGIONS; i++) begin
      if (CNT_W'(i) < cnt_q[active_q] &&
          slot_lo_q[active_q][i] <= pix_x && pix_x <= slot_hi_q[active_q][i])
        any_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      active_q      <= 1'b0;
      loaded_q      <= 1'b0;
      drain_q       <= 1'b0;
      target_q      <= '0;
      num_q         <= '0;
      rd_addr_q     <= '0;
      cnt_q[0]      <= '0;
      cnt_q[1]      <= '0;
      vld_p0_q      <= 1'b0;
      vld_p1_q      <= 1'b0;
      overflow_q    <= 1'b0;
      late_q        <= 1'b0;
      match_q       <= 1'b0;
      match_valid_q <= 1'b0;
    end else begin
      vld_p0_q <= (state_q == ST_BUILD) && !flush;
      vld_p1_q <= vld_p0_q && !flush;
      if (do_wr)  cnt_q[wr_bank] <= wr_cnt + CNT_ONE;
      if (do_ovf) overflow_q <= 1'b1;

      case (state_q)
        ST_BUILD: begin
          rd_addr_q <= rd_addr_q + ADDR_ONE;
          if (rd_addr_q + ADDR_ONE == num_q) begin
            state_q <= ST_DRAIN;
            drain_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (drain_q) state_q <= ST_READY;
          drain_q <= 1'b1;
        end
        default: ;
      endcase

      if (ready_sol) begin
        active_q <= ~active_q;
        loaded_q <= 1'b1;
        if (!next_ok) state_q <= ST_IDLE;
      end
      if (late_sol) begin
        cnt_q[active_q] <= '0;
        late_q          <= 1'b1;
        if (!next_ok) state_q <= ST_IDLE;
      end
      if (start) begin
        target_q        <= sof_go ? '0 : target_q + Y_BITS'(1);
        cnt_q[bld_bank] <= '0;
        num_q           <= cfg_num;
        rd_addr_q       <= '0;
        state_q         <= (cfg_num == '0) ? ST_READY : ST_BUILD;
      end
      if (sof) begin
        overflow_q <= 1'b0;
        late_q     <= 1'b0;
      end
      if (sof_go) loaded_q <= 1'b0;

      match_valid_q <= pix_valid;
      match_q       <= pix_valid && enable && (state_q != ST_IDLE || loaded_q) && any_hit;
    end
  end

  // Fetch-return register and slot storage carry no reset.
  always_ff @(posedge clk) begin
    coord_x_p1_q <= rdata[CFG_X_LSB +: X_BITS];
    coord_y_p1_q <= rdata[CFG_Y_LSB +: Y_BITS];
    if (do_wr) begin
      slot_lo_q[wr_bank][wr_cnt[CNT_W-2:0]] <= reg_c.x_lo[X_BITS-1:0];
      slot_hi_q[wr_bank][wr_cnt[CNT_W-2:0]] <= reg_c.x_hi[X_BITS-1:0];
    end
  end

  assign match_valid     = match_valid_q;
  assign match           = match_q;
  assign region_overflow = overflow_q;
  assign build_late      = late_q;
  assign busy            = (state_q == ST_BUILD) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_manual_region_prefetch_checker.sv
// Directed bench for the manual region prefetch checker (RADIUS 2 and RADIUS 0 instances).
module tb_manual_region_prefetch_checker;

  logic       clk = 1'b0;
  logic       rst, pix_valid, sof, sol, enable, cfg_we;
  logic [9:0] pix_x;
  logic [6:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic [7:0] cfg_num;
  logic match_valid, match, region_overflow, build_late, busy;
  logic mv_r0, m_r0, ovf_r0, late_r0, busy_r0;
  int   n_chk = 0, n_pass = 0;
  bit   inl;

  always #5 clk = ~clk;

  manual_region_prefetch_checker dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_x(pix_x), .sof(sof), .sol(sol),
    .enable(enable), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_num(cfg_num), .match_valid(match_valid), .match(match),
    .region_overflow(region_overflow), .build_late(build_late), .busy(busy)
  );

  manual_region_prefetch_checker #(.RADIUS(0)) dut_r0 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_x(pix_x), .sof(sof), .sol(sol),
    .enable(enable), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_num(cfg_num), .match_valid(mv_r0), .match(m_r0),
    .region_overflow(ovf_r0), .build_late(late_r0), .busy(busy_r0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_sof();
    sof = 1'b1; tick(); sof = 1'b0;
  endtask

  task automatic pulse_sol();
    sol = 1'b1; tick(); sol = 1'b0;
  endtask

  task automatic wr(input int a, input int x, input int y);
    cfg_we = 1'b1; cfg_addr = a[6:0]; cfg_wdata = {y[15:0], x[15:0]};
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic px(input string tag, input int x, input bit exp);
    pix_valid = 1'b1; pix_x = x[9:0];
    tick();
    pix_valid = 1'b0;
    chk(tag, {31'd0, match}, {31'd0, exp});
  endtask

  task automatic pxr0(input string tag, input int x, input bit exp);
    pix_valid = 1'b1; pix_x = x[9:0];
    tick();
    pix_valid = 1'b0;
    chk(tag, {31'd0, m_r0}, {31'd0, exp});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pix_valid = 1'b0; sof = 1'b0; sol = 1'b0; enable = 1'b1;
    cfg_we = 1'b0; pix_x = '0; cfg_addr = '0; cfg_wdata = '0; cfg_num = '0;
    idle(2);
    chk("rst match_valid", {31'd0, match_valid}, 0);
    chk("rst match", {31'd0, match}, 0);
    chk("rst overflow", {31'd0, region_overflow}, 0);
    chk("rst late", {31'd0, build_late}, 0);
    chk("rst busy", {31'd0, busy}, 0);
    rst = 1'b0;
    idle(2);

    // Single point (100,50), radius 2
    cfg_num = 8'd1;
    wr(0, 100, 50);
    pulse_sof();
    chk("s1 busy after sof", {31'd0, busy}, 1);
    idle(6);
    for (int L = 0; L <= 53; L++) begin
      pulse_sol();
      if (L >= 47) begin
        inl = (L >= 48 && L <= 52);
        px($sformatf("s1 L%0d x97", L), 97, 1'b0);
        px($sformatf("s1 L%0d x98", L), 98, inl);
        px($sformatf("s1 L%0d x100", L), 100, inl);
        chk($sformatf("s1 L%0d mvalid", L), {31'd0, match_valid}, 1);
        px($sformatf("s1 L%0d x102", L), 102, inl);
        px($sformatf("s1 L%0d x103", L), 103, 1'b0);
        tick();
        chk($sformatf("s1 L%0d idle mvalid", L), {31'd0, match_valid}, 0);
        chk($sformatf("s1 L%0d idle match", L), {31'd0, match}, 0);
      end
      idle(6);
    end

    // Corner points with left-edge saturation and right-edge clamp
    cfg_num = 8'd2;
    wr(0, 0, 0);
    wr(1, 639, 511);
    pulse_sof();
    idle(7);
    for (int L = 0; L < 512; L++) begin
      pulse_sol();
      if (L == 0) begin
        px("s2 L0 x0", 0, 1'b1);
        px("s2 L0 x2", 2, 1'b1);
        px("s2 L0 x3", 3, 1'b0);
        px("s2 L0 x639", 639, 1'b0);
      end
      if (L == 1) px("s2 L1 x2", 2, 1'b1);
      if (L == 3) px("s2 L3 x0", 0, 1'b0);
      if (L == 508) px("s2 L508 x639", 639, 1'b0);
      if (L >= 509) begin
        px($sformatf("s2 L%0d x636", L), 636, 1'b0);
        px($sformatf("s2 L%0d x637", L), 637, 1'b1);
        px($sformatf("s2 L%0d x639", L), 639, 1'b1);
        px($sformatf("s2 L%0d x1023", L), 1023, 1'b0);
        px($sformatf("s2 L%0d x0", L), 0, 1'b0);
      end
      idle(7);
    end
    chk("s2 idle after frame", {31'd0, busy}, 0);

    // Seventeen points on line 10: slot overflow
    cfg_num = 8'd17;
    for (int i = 0; i < 17; i++) wr(i, 20 + 20 * i, 10);
    pulse_sof();
    idle(22);
    for (int L = 0; L <= 8; L++) begin
      pulse_sol();
      if (L == 8) begin
        px("s3 x340", 340, 1'b0);
        px("s3 x320", 320, 1'b1);
        px("s3 x338", 338, 1'b0);
        px("s3 x20", 20, 1'b1);
      end
      idle(22);
      if (L == 6) chk("s3 ovf before line8 build", {31'd0, region_overflow}, 0);
      if (L == 7) chk("s3 ovf after line8 build", {31'd0, region_overflow}, 1);
    end
    pulse_sof();
    chk("s3 ovf cleared by sof", {31'd0, region_overflow}, 0);

    // 100-entry table: late sol then adequate spacing
    cfg_num = 8'd100;
    for (int i = 0; i < 99; i++) wr(i, 1000, 1000);
    wr(99, 300, 1);
    pulse_sof();
    idle(58);
    for (int L = 0; L < 3; L++) begin
      pulse_sol();
      chk($sformatf("s4 late L%0d", L), {31'd0, build_late}, 1);
      px($sformatf("s4 late L%0d x300", L), 300, 1'b0);
      idle(58);
    end
    pulse_sof();
    chk("s4 late cleared", {31'd0, build_late}, 0);
    idle(108);
    for (int L = 0; L < 3; L++) begin
      pulse_sol();
      px($sformatf("s4 L%0d x300", L), 300, 1'b1);
      px($sformatf("s4 L%0d x297", L), 297, 1'b0);
      px($sformatf("s4 L%0d x303", L), 303, 1'b0);
      idle(106);
      chk($sformatf("s4 on-time late L%0d", L), {31'd0, build_late}, 0);
    end

    // Radius 0: only pixel (5,5)
    cfg_num = 8'd1;
    wr(0, 5, 5);
    pulse_sof();
    idle(6);
    for (int L = 0; L <= 6; L++) begin
      pulse_sol();
      if (L == 4) begin
        pxr0("r0 L4 x5", 5, 1'b0);
        px("r2 L4 x5", 5, 1'b1);
      end
      if (L == 5) begin
        pxr0("r0 L5 x4", 4, 1'b0);
        pxr0("r0 L5 x5", 5, 1'b1);
        pxr0("r0 L5 x6", 6, 1'b0);
      end
      if (L == 6) pxr0("r0 L6 x5", 5, 1'b0);
      idle(6);
    end

    // Asynchronous reset in the middle of a build
    cfg_num = 8'd100;
    pulse_sof();
    idle(5);
    pulse_sol();
    pix_valid = 1'b1; pix_x = 10'd0;
    tick();
    pix_valid = 1'b0;
    chk("s6 pre mvalid", {31'd0, match_valid}, 1);
    chk("s6 pre busy", {31'd0, busy}, 1);
    chk("s6 pre late", {31'd0, build_late}, 1);
    #2 rst = 1'b1;
    #1;
    chk("s6 async mvalid", {31'd0, match_valid}, 0);
    chk("s6 async match", {31'd0, match}, 0);
    chk("s6 async busy", {31'd0, busy}, 0);
    chk("s6 async late", {31'd0, build_late}, 0);
    chk("s6 async ovf", {31'd0, region_overflow}, 0);
    chk("s6 r0 busy", {31'd0, busy_r0}, 0);
    chk("s6 r0 late", {31'd0, late_r0}, 0);
    chk("s6 r0 ovf", {31'd0, ovf_r0}, 0);
    chk("s6 r0 mvalid", {31'd0, mv_r0}, 0);
    tick();
    rst = 1'b0;
    tick();
    pulse_sof();
    idle(108);
    pulse_sol();
    px("s6 L0 x300", 300, 1'b1);
    px("s6 L0 x5", 5, 1'b0);
    chk("s6 late after rebuild", {31'd0, build_late}, 0);
    enable = 1'b0;
    px("s6 disabled x300", 300, 1'b0);
    enable = 1'b1;
    px("s6 reenabled x300", 300, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/manual_region_prefetch_checker.md
Name: manual_region_prefetch_checker

Overview:
- Successor to the manual bad-pixel checker in the DPC corrector path. Holds up to PT_NUM manually configured bad coordinates and flags every pixel inside a (2*RADIUS+1)-square region around each one.
- While the current line streams, it prefetches the region list for the next line into the idle half of a ping-pong region cache. No pixels are stalled or missed during cache rebuilds.
- New relative to the previous generation: parametrised radius, right-edge clamping, registered result with a valid qualifier, an overflow flag and a late-build flag.

Parameters:
- X_BITS, 10, pixel X coordinate width.
- Y_BITS, 10, pixel Y coordinate width.
- PT_NUM, 128, coordinate table depth.
- PT_BIT, 7, table address width, equal to log2(PT_NUM).
- RADIUS, 2, region half-size. Legal range 0..7.
- MAX_REGIONS, 16, region slots per cache bank. Must be a power of 2.
- IMAGE_WIDTH, 640, active width, used for right-edge clamping.
- IMAGE_HEIGHT, 512, lines per frame.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- pix_valid  in  1  pixel strobe.
- pix_x  in  X_BITS  current pixel X.
- sof  in  1  one-cycle start-of-frame pulse, issued in vertical blanking.
- sol  in  1  one-cycle start-of-line pulse, issued before the first pixel of each line.
- enable  in  1  checker enable.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  PT_BIT  table write address.
- cfg_wdata  in  32  {Y[15:0], X[15:0]}, truncated to Y_BITS / X_BITS.
- cfg_num  in  PT_BIT+1  number of valid entries, 0..PT_NUM.
- match_valid  out  1  pix_valid delayed by 1 cycle.
- match  out  1  pixel lies inside a manual region.
- region_overflow  out  1  sticky: some line needed more than MAX_REGIONS slots.
- build_late  out  1  sticky: an sol arrived before the prefetch completed.
- busy  out  1  FSM is in BUILD or DRAIN.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; both bank counts 0; active bank A; line counter 0. Table RAM contents are not reset. Reset may be asserted at any time, including mid-build, and aborts all activity.
- Table: single-port write, synchronous read with 1-cycle latency. cfg writes may occur at any time and affect only builds that start after the write. cfg_num is latched at every build start.
- Region arithmetic, with widths extended by 1 bit so no wrap occurs:
  - y_lo = max(by-RADIUS, 0), y_hi = by+RADIUS.
  - x_lo = max(bx-RADIUS, 0), x_hi = min(bx+RADIUS, IMAGE_WIDTH-1).
  - A point hits target line T iff y_lo <= T <= y_hi.
  - Each slot stores {x_hi, x_lo}, 2*X_BITS bits wide.
- FSM states: IDLE, BUILD, DRAIN, READY.
  - IDLE: on sof with enable high, set target=0, clear the inactive bank count, latch cfg_num, go to BUILD. If the latched count is 0, go straight to READY.
  - BUILD: issue one read address per cycle, 0..cfg_num-1. Data returns 1 cycle later and is evaluated 1 cycle after that. After the last address, go to DRAIN.
  - DRAIN: 2 cycles to flush the pipeline, then READY. Total build latency is cfg_num+3 cycles from build start.
  - Hit handling: each hit writes slot[count] and increments count. A hit with count == MAX_REGIONS is dropped and sets region_overflow.
  - READY, on sol: swap banks (active <= inactive). If target+1 < IMAGE_HEIGHT, set target += 1 and start a BUILD into the freed bank; otherwise go to IDLE.
  - sol while in BUILD or DRAIN: set build_late; force the active bank count to 0 for this line (fail-safe: no matches); restart the build for target+1.
  - sol while in IDLE: ignored.
- sof handling:
  - sof in any state aborts the current build, resets the line counter and restarts the line-0 build.
  - sof clears region_overflow and build_late.
  - sof and sol in the same cycle: sof wins and sol is ignored.
- Matching: 1 cycle of latency.
  - match_valid <= pix_valid.
  - match <= pix_valid && enable && (state != IDLE or the active bank was loaded this frame) && OR over i < active_count of (x_lo_i <= pix_x <= x_hi_i).
  - match is 0 whenever match_valid is 0.
- enable low: match is 0. The FSM completes any in-flight build but starts no new frame.
- Timing contract: sol spacing must be at least cfg_num+4 cycles. The sof to first-sol gap must also be at least cfg_num+4 cycles. Violations are reported via build_late only; no other error handling is performed.

Decomposition:
- Package manual_dpc_pkg:
  - FSM state enum.
  - Coordinate field slice constants (Y at [31:16], X at [15:0]).
  - Region slot struct {x_hi, x_lo}.
  - Saturating subtract and clamp functions.
- Sub-module manual_coord_ram: PT_NUM x 32, write port plus 1-cycle registered read port. All other logic stays in the top.

Test Plan:
- One point (100,50), cfg_num=1, RADIUS=2 -> match=1 for x=98..102 on lines 48..52. match=0 for x=97 and x=103, and for all of lines 47 and 53. Response is 1 cycle after each pixel.
- Corner points (0,0) and (639,511) -> line 0 matches only x=0..2. Lines 509..511 match only x=637..639. No wrap hits on line 1023 or at x=1023.
- Seventeen points all at y=10, x=20,40,...,340 -> region_overflow rises during the build for line 8. x=340 never matches; x=320 matches. A new sof clears the flag.
- cfg_num=100 with sol every 60 cycles -> build_late=1 and match=0 on every line. Rerun with 110-cycle spacing after sof -> build_late stays 0 and matches are correct.
- Build with RADIUS=0 and point (5,5) -> exactly one match, at pixel (5,5).
- Assert rst for 1 cycle mid-BUILD -> all outputs 0 asynchronously. The next sof performs a normal build and matches resume from line 0.
